psum_out_collector: RTL and testbench

- Consumes the rectified partial-sum stream leaving the conv partial-sum buffer: a 25-bit value plus a one-cycle valid strobe, with no backpressure.
- Requantizes each value to 8 bits and packs four values per 32-bit word.
- Buffers packed words in a small FIFO and writes them to output feature-map SRAM through a valid/ready write port at sequential addresses.
- Tracks frame progress (rows x cols outputs) and pulses done when the last word has been written.

---
 rtl/psum_out_collector.sv | 196 +++++++++++++++++++
 tb/tb_psum_out_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_out_collector.sv
// psum_out_collector
// Takes the rectified partial-sum stream, requantizes each value to one byte,
// packs four bytes per 32-bit word and writes the packed words to the output
// feature-map SRAM at sequential addresses. An internal FIFO absorbs SRAM
// stalls. done pulses once the last word of the frame has been written.
//
// Handshake on the write port: a write is transferred on every rising clk
// edge where wr_valid && wr_ready. While wr_valid is high and wr_ready is
// low, wr_addr/wr_data hold the same head entry. wr_valid never depends on
// wr_ready. The input stream has no backpressure: every in_valid cycle in
// RUN is consumed.
module psum_out_collector #(
  parameter int data_width  = 25,
  parameter int shift_width = 5,
  parameter int dim_width   = 8,
  parameter int addr_width  = 16,
  parameter int fifo_depth  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [shift_width-1:0] cfg_shift,
  input  logic [dim_width-1:0]   cfg_out_rows,
  input  logic [dim_width-1:0]   cfg_out_cols,
  input  logic [addr_width-1:0]  cfg_base_addr,
  input  logic [data_width-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [addr_width-1:0]  wr_addr,
  output logic [31:0]            wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int ptr_w   = $clog2(fifo_depth);
  localparam int entry_w = addr_width + 32;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t state_q, state_d;

  // Latched frame configuration.
  logic [shift_width-1:0] shift_r;
  logic [dim_width-1:0]   rows_r, cols_r;
  logic [addr_width-1:0]  base_r;

  // Frame progress.
  logic [1:0]            lane_q;
  logic [dim_width-1:0]  col_q, row_q;
  logic [addr_width-1:0] word_q;
  logic [7:0]            byte0_q, byte1_q, byte2_q;

  // FIFO storage: {address, data} per entry.
  logic [entry_w-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]   wr_ptr, rd_ptr;
  logic [ptr_w:0]     count;

  logic                  start_acc, accept, is_last;
  logic [data_width-1:0] q_full;
  logic [7:0]            q_byte;
  logic                  push, do_push, pop, fifo_full, fifo_empty;
  logic [31:0]           push_data;
  logic [addr_width-1:0] push_addr;
  logic [entry_w-1:0]    head;

  assign start_acc  = (state_q == IDLE) && cfg_start;
  assign accept     = (state_q == RUN) && in_valid;
  assign is_last    = (row_q == rows_r - dim_width'(1)) && (col_q == cols_r - dim_width'(1));

  assign q_full     = in_data >> shift_r;
  assign q_byte     = (|q_full[data_width-1:8]) ? 8'hFF : q_full[7:0];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (ptr_w+1)'(fifo_depth));
  assign pop        = !fifo_empty && wr_ready;
  assign push       = accept && ((lane_q == 2'd3) || is_last);
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_push    = push && (!fifo_full || pop);
  assign push_addr  = base_r + word_q;

  // Assemble the outgoing word; lanes above the current one are zero so a
  // short final word carries no bytes from the previous word.
  always_comb begin
    push_data = 32'h0;
    case (lane_q)
      2'd0: push_data = {24'h0, q_byte};
      2'd1: push_data = {16'h0, q_byte, byte0_q};
      2'd2: push_data = {8'h0, q_byte, byte1_q, byte0_q};
      default: push_data = {q_byte, byte2_q, byte1_q, byte0_q};
    endcase
  end

  // Show-ahead write port; address and data read as zero when idle.
  assign head     = mem[rd_ptr];
  assign wr_valid = !fifo_empty;
  assign wr_addr  = wr_valid ? head[entry_w-1:32] : '0;
  assign wr_data  = wr_valid ? head[31:0] : 32'h0;

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cfg_start)
               state_d = ((cfg_out_rows == '0) || (cfg_out_cols == '0)) ? DONE : RUN;
      RUN:   if (accept && is_last) state_d = FLUSH;
      FLUSH: if (fifo_empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the registered busy/done/overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (start_acc) begin
        busy     <= 1'b1;
        overflow <= 1'b0;
      end else if (state_q == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Configuration latch and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      rows_r  <= '0;
      cols_r  <= '0;
      base_r  <= '0;
      lane_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      word_q  <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
      byte2_q <= '0;
    end else if (start_acc) begin
      shift_r <= cfg_shift;
      rows_r  <= cfg_out_rows;
      cols_r  <= cfg_out_cols;
      base_r  <= cfg_base_addr;
      lane_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      word_q  <= '0;
    end else if (accept) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0: byte0_q <= q_byte;
        2'd1: byte1_q <= q_byte;
        2'd2: byte2_q <= q_byte;
        default: ;
      endcase
      if (col_q == cols_r - dim_width'(1)) begin
        col_q <= '0;
        row_q <= row_q + dim_width'(1);
      end else begin
        col_q <= col_q + dim_width'(1);
      end
      // Dropped words still consume an address slot.
      if (push) word_q <= word_q + addr_width'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)     rd_ptr <= rd_ptr + ptr_w'(1);
      count <= count + (ptr_w+1)'(do_push) - (ptr_w+1)'(pop);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

endmodule

// File: tb/tb_psum_out_collector.sv
// Directed bench for psum_out_collector: basic packing, requantization,
// partial last word, backpressure/overflow, ignored inputs, empty frame and
// reset mid-frame.
module tb_psum_out_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_out_rows, cfg_out_cols;
  logic [15:0] cfg_base_addr;
  logic [24:0] in_data;
  logic        in_valid;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, overflow;

  int n_pass  = 0;
  int n_check = 0;
  int done_cnt = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];

  psum_out_collector dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_shift(cfg_shift),
    .cfg_out_rows(cfg_out_rows), .cfg_out_cols(cfg_out_cols),
    .cfg_base_addr(cfg_base_addr), .in_data(in_data), .in_valid(in_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
  );

  // Clock.
  always #5 clk = ~clk;

  // Write and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) obs_q.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    n_check++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] rows, input logic [7:0] cols,
                       input logic [4:0] sh, input logic [15:0] base);
    cfg_out_rows  = rows;
    cfg_out_cols  = cols;
    cfg_shift     = sh;
    cfg_base_addr = base;
    cfg_start     = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [24:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done) break;
      step();
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_shift = '0; cfg_out_rows = '0;
    cfg_out_cols = '0; cfg_base_addr = '0; in_data = '0; in_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (3) step();
    chk("rst_outputs", {wr_valid, busy, done, overflow, wr_addr, wr_data}, '0);
    rst = 1'b0;
    step();

    // Basic frame.
    done_cnt = 0;
    start(8'd1, 8'd4, 5'd0, 16'h0100);
    chk("basic_busy", busy, 1);
    send(25'd1); send(25'd2); send(25'd3);
    chk("basic_no_early_valid", wr_valid, 0);
    send(25'd4);
    chk("basic_valid", wr_valid, 1);
    chk("basic_head", {wr_addr, wr_data}, {16'h0100, 32'h04030201});
    wait_done("basic", 20);
    chk("basic_ovf", overflow, 0);
    repeat (3) step();
    chk("basic_done_once", done_cnt, 1);
    exp_q.push_back({16'h0100, 32'h04030201});
    check_writes("basic");

    // Quantization with saturation.
    start(8'd1, 8'd4, 5'd2, 16'h0020);
    send(25'd1023); send(25'd1024); send(25'd7); send(25'd0);
    wait_done("quant", 20);
    exp_q.push_back({16'h0020, 32'h0001FFFF});
    check_writes("quant");

    // Partial last word across rows.
    start(8'd2, 8'd3, 5'd0, 16'h0010);
    for (int i = 1; i <= 6; i++) send(25'(i));
    wait_done("partial", 20);
    exp_q.push_back({16'h0010, 32'h04030201});
    exp_q.push_back({16'h0011, 32'h00000605});
    check_writes("partial");

    // Backpressure and overflow.
    wr_ready = 1'b0;
    start(8'd1, 8'd40, 5'd0, 16'h0200);
    for (int i = 1; i <= 40; i++) send(25'(i));
    chk("bp_overflow", overflow, 1);
    chk("bp_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_head_stable", {wr_valid, wr_addr, wr_data}, {1'b1, 16'h0200, 32'h04030201});
      step();
    end
    wr_ready = 1'b1;
    wait_done("bp", 30);
    chk("bp_ovf_held", overflow, 1);
    for (int w = 0; w < 8; w++)
      exp_q.push_back({16'h0200 + 16'(w),
                       8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
    check_writes("bp");

    // Ignored in_valid in IDLE and ignored second start in RUN.
    send(25'h55); send(25'h66);
    chk("idle_no_write", wr_valid, 0);
    done_cnt = 0;
    start(8'd1, 8'd4, 5'd0, 16'h0300);
    chk("start_clears_ovf", overflow, 0);
    send(25'd1);
    cfg_out_rows = 8'd3; cfg_base_addr = 16'h0999;
    cfg_start = 1'b1; in_valid = 1'b1; in_data = 25'd2;
    step();
    cfg_start = 1'b0; in_valid = 1'b0;
    send(25'd3); send(25'd4);
    wait_done("ign", 20);
    repeat (4) step();
    chk("ign_done_once", done_cnt, 1);
    exp_q.push_back({16'h0300, 32'h04030201});
    check_writes("ign");

    // Empty frame: done two cycles after cfg_start.
    start(8'd0, 8'd5, 5'd0, 16'h0400);
    chk("zero_first", {busy, done}, 2'b10);
    step();
    chk("zero_second", {busy, done}, 2'b01);
    step();
    check_writes("zero");

    // Reset mid-frame.
    wr_ready = 1'b0;
    start(8'd1, 8'd8, 5'd0, 16'h0400);
    for (int i = 1; i <= 6; i++) send(25'(i));
    chk("rmf_pending", wr_valid, 1);
    rst = 1'b1;
    #1;
    chk("rmf_outputs", {wr_valid, busy, done, overflow, wr_addr, wr_data}, '0);
    step();
    rst = 1'b0;
    wr_ready = 1'b1;
    repeat (3) step();
    chk("rmf_empty", wr_valid, 0);
    check_writes("rmf");
    start(8'd1, 8'd4, 5'd0, 16'h0500);
    send(25'd9); send(25'd10); send(25'd11); send(25'd12);
    wait_done("post_rst", 20);
    exp_q.push_back({16'h0500, 32'h0C0B0A09});
    check_writes("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
